// File: rtl/seg_display_decoder_if.sv
// Request/result bundle for seg_display_decoder: a snapshot request goes in,
// a decoded signed value with its flags comes back.
interface seg_display_decoder_if #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned RES_W      = 20
);
  logic                         start;
  logic [0:NUM_DIGITS-1][7:0]   seg_in;
  logic                         busy;
  logic                         out_valid;
  logic [RES_W-1:0]             value;
  logic                         neg;
  logic                         err;

  modport master (
    output start, seg_in,
    input  busy, out_valid, value, neg, err
  );

  modport slave (
    input  start, seg_in,
    output busy, out_valid, value, neg, err
  );
endinterface

// File: rtl/seg_display_decoder.sv
// Snapshots a row of seven-segment patterns and decodes them most significant
// digit first, one per clock, into a signed two's-complement value.
module seg_display_decoder #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned RES_W      = 20,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  seg_display_decoder_if.slave bus
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] TopIdx = IdxW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [7:0]       r_snap [NUM_DIGITS];
  logic [IdxW-1:0]  r_idx;
  logic [RES_W-1:0] r_acc;
  logic             r_neg_acc, r_err_acc;
  logic             r_busy, r_out_valid, r_neg, r_err;
  logic [RES_W-1:0] r_value;

  logic [6:0]       w_pat;
  logic [3:0]       w_digit;
  logic             w_minus, w_illegal;
  logic [RES_W-1:0] w_acc_next;
  logic             w_unused_dp;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (bus.start) w_state_d = StScan;
      StScan:  if (r_idx == '0) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Digit decode of the snapshot entry under the scan index
  always_comb begin
    w_pat       = ACTIVE_LOW ? ~r_snap[r_idx][6:0] : r_snap[r_idx][6:0];
    w_unused_dp = r_snap[r_idx][7];
    w_digit     = 4'd0;
    w_minus     = 1'b0;
    w_illegal   = 1'b0;
    case (w_pat)
      7'h3F, 7'h00: w_digit = 4'd0;
      7'h06:        w_digit = 4'd1;
      7'h5B:        w_digit = 4'd2;
      7'h4F:        w_digit = 4'd3;
      7'h66:        w_digit = 4'd4;
      7'h6D:        w_digit = 4'd5;
      7'h7D:        w_digit = 4'd6;
      7'h07:        w_digit = 4'd7;
      7'h7F:        w_digit = 4'd8;
      7'h6F:        w_digit = 4'd9;
      7'h40: begin
        if (r_idx == TopIdx) w_minus   = 1'b1;
        else                 w_illegal = 1'b1;
      end
      default:      w_illegal = 1'b1;
    endcase
    w_acc_next = r_acc * RES_W'(10) + RES_W'(w_digit);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) r_snap[i] <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_neg_acc   <= 1'b0;
      r_err_acc   <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_value     <= '0;
      r_neg       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_busy      <= (w_state_d == StScan);
      r_out_valid <= (r_state == StDone);
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) r_snap[i] <= bus.seg_in[i];
            r_acc     <= '0;
            r_idx     <= TopIdx;
            r_neg_acc <= 1'b0;
            r_err_acc <= 1'b0;
          end
        end
        StScan: begin
          // A leading minus only flags the sign; the magnitude is untouched.
          if (w_minus) r_neg_acc <= 1'b1;
          else         r_acc     <= w_acc_next;
          if (w_illegal) r_err_acc <= 1'b1;
          if (r_idx != '0) r_idx <= r_idx - 1'b1;
        end
        StDone: begin
          r_value <= r_neg_acc ? -r_acc : r_acc;
          r_neg   <= r_neg_acc;
          r_err   <= r_err_acc;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.value     = r_value;
  assign bus.neg       = r_neg;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_seg_display_decoder.sv
// Self-checking bench for seg_display_decoder: directed cases with literal
// expectations plus randomized traffic compared every cycle to a reference model.
module tb_seg_display_decoder;

  localparam int unsigned ND = 6;
  localparam int unsigned RW = 20;
  typedef logic [0:ND-1][7:0] seg_t;

  localparam logic [6:0] TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [6:0] MINUS = 7'h40;
  localparam logic [6:0] BLANK = 7'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_display_decoder_if #(.NUM_DIGITS(ND), .RES_W(RW)) bus ();

  seg_display_decoder #(
    .NUM_DIGITS (ND),
    .RES_W      (RW),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Active-low encoding with a random decimal point, which must be ignored.
  function automatic logic [7:0] enc(input logic [6:0] p);
    logic dp;
    dp = 1'($urandom_range(0, 1));
    return {dp, ~p};
  endfunction

  // Reference: read the display left to right as a decimal string.
  function automatic void model_decode(input seg_t s, output logic [RW-1:0] v,
                                       output logic n, output logic e);
    longint mag;
    logic [6:0] p;
    int d;
    mag = 0;
    n = 1'b0;
    e = 1'b0;
    for (int i = ND - 1; i >= 0; i--) begin
      p = ~s[i][6:0];
      d = -1;
      if (p == BLANK) d = 0;
      for (int k = 0; k < 10; k++) if (p == TBL[k]) d = k;
      if (d < 0 && p == MINUS && i == ND - 1) begin
        n = 1'b1;
      end else begin
        if (d < 0) begin
          e = 1'b1;
          d = 0;
        end
        mag = (mag * 10 + d) % (longint'(1) << RW);
      end
    end
    v = RW'(mag);
    if (n) v = -v;
  endfunction

  function automatic seg_t rand_seg();
    seg_t s;
    int r;
    for (int i = 0; i < ND; i++) begin
      r = $urandom_range(0, 19);
      if (r < 12)       s[i] = enc(TBL[r % 10]);
      else if (r < 15)  s[i] = enc(BLANK);
      else if (r == 15) s[i] = enc(7'($urandom));
      else if (r == 16) s[i] = enc(MINUS);
      else              s[i] = enc(TBL[$urandom_range(0, 9)]);
    end
    if ($urandom_range(0, 3) == 0) s[ND-1] = enc(MINUS);
    return s;
  endfunction

  // Timing model: a request accepted at edge N publishes at edge N+ND+1.
  int               m_cnt   = 0;
  logic             m_busy  = 1'b0;
  logic             m_valid = 1'b0;
  logic [RW-1:0]    m_value = '0;
  logic             m_neg   = 1'b0;
  logic             m_err   = 1'b0;
  logic [RW-1:0]    p_value;
  logic             p_neg, p_err;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_cnt = 0; m_busy = 1'b0; m_valid = 1'b0;
      m_value = '0; m_neg = 1'b0; m_err = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_cnt == 0) begin
        if (bus.start) begin
          model_decode(bus.seg_in, p_value, p_neg, p_err);
          m_cnt = 1;
        end
      end else begin
        m_cnt++;
        if (m_cnt == ND + 2) begin
          m_valid = 1'b1;
          m_value = p_value;
          m_neg   = p_neg;
          m_err   = p_err;
          m_cnt   = 0;
        end
      end
      m_busy = (m_cnt >= 1 && m_cnt <= ND);
    end
  end

  initial forever begin
    @(negedge clk);
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("value", 32'(bus.value), 32'(m_value));
    check("neg", 32'(bus.neg), 32'(m_neg));
    check("err", 32'(bus.err), 32'(m_err));
    if (bus.out_valid === 1'b1) n_pulses++;
  end

  task automatic req(input seg_t s);
    @(posedge clk); #1;
    bus.seg_in = s;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int lat;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        lat = i - 1;
        break;
      end
    end
    check({name, "_latency"}, 32'(lat), 32'(ND + 1));
  endtask

  task automatic check_result(input string name, input logic [RW-1:0] v,
                              input logic n, input logic e);
    check({name, "_value"}, 32'(bus.value), 32'(v));
    check({name, "_neg"}, 32'(bus.neg), 32'(n));
    check({name, "_err"}, 32'(bus.err), 32'(e));
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_valid"}, 32'(bus.out_valid), 32'd0);
    check_result(name, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    seg_t s1, s;
    int   p0;
    bus.start  = 1'b0;
    bus.seg_in = '1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;

    // Digits 0..5 = 5,4,3,2,1,0
    for (int i = 0; i < ND; i++) s1[i] = enc(TBL[5 - i]);
    req(s1);
    wait_result("t1");
    check_result("t1", 20'd12345, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("t1_single_pulse", 32'(bus.out_valid), 32'd0);

    // Minus, blanks, then 07
    s[5] = enc(MINUS); s[4] = enc(BLANK); s[3] = enc(BLANK); s[2] = enc(BLANK);
    s[1] = enc(TBL[0]); s[0] = enc(TBL[7]);
    req(s);
    wait_result("t2");
    check_result("t2", 20'hFFFF9, 1'b1, 1'b0);

    // Illegal pattern, then recovery
    for (int i = 0; i < ND; i++) s[i] = enc(TBL[0]);
    s[2] = enc(7'h55);
    req(s);
    wait_result("t3");
    check_result("t3", 20'd0, 1'b0, 1'b1);
    req(s1);
    wait_result("t3b");
    check_result("t3b", 20'd12345, 1'b0, 1'b0);

    // Minus below the top digit
    for (int i = 0; i < ND; i++) s[i] = enc(TBL[0]);
    s[1] = enc(MINUS);
    req(s);
    wait_result("t4");
    check_result("t4", 20'd0, 1'b0, 1'b1);

    // Minus zero
    for (int i = 0; i < ND; i++) s[i] = enc(TBL[0]);
    s[5] = enc(MINUS);
    req(s);
    wait_result("neg_zero");
    check_result("neg_zero", 20'd0, 1'b1, 1'b0);

    // Starts and input changes during SCAN are ignored
    p0 = n_pulses;
    req(s1);
    for (int k = 1; k <= ND; k++) begin
      @(posedge clk); #1;
      bus.start  = (k == 1 || k == 3);
      bus.seg_in = rand_seg();
    end
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("t5_pulses", 32'(n_pulses - p0), 32'd1);
    check_result("t5", 20'd12345, 1'b0, 1'b0);

    // Reset in the third SCAN cycle
    s[5] = enc(MINUS); s[4] = enc(TBL[9]); s[3] = enc(TBL[8]);
    s[2] = enc(TBL[7]); s[1] = enc(TBL[6]); s[0] = enc(TBL[5]);
    req(s);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_zero_outputs("t6_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    p0 = n_pulses;
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_pulse", 32'(n_pulses - p0), 32'd0);
    req(s);
    wait_result("t6");
    check_result("t6", -20'd98765, 1'b1, 1'b0);

    // Randomized traffic, including back-to-back and ignored starts
    p0 = n_pulses;
    for (int c = 0; c < 600; c++) begin
      int r;
      @(posedge clk); #1;
      r = $urandom_range(0, 3);
      bus.start = (r == 0);
      if (r <= 1) bus.seg_in = rand_seg();
    end
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("random_pulses_seen", 32'(n_pulses - p0 > 20), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
